// File: rtl/day1_pkg.sv
// day1_pkg: shared ASCII constants, parser state encoding and default widths for the day-1 dial path
package day1_pkg;
  localparam int DEF_MAG_WIDTH = 16;
  localparam logic [7:0] CH_L  = 8'h4c;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_SP = 8'h20;
  typedef enum logic [1:0] {IDLE, DIGITS, SKIP} parse_state_t;
endpackage

// File: rtl/day1_dec_acc.sv
// day1_dec_acc: one decimal step acc*10+digit, saturating to all-ones with an overflow flag
module day1_dec_acc import day1_pkg::*; #(
  parameter int MAG_WIDTH = DEF_MAG_WIDTH
) (
  input  logic [MAG_WIDTH-1:0] acc_i,
  input  logic [3:0]           digit_i,
  output logic [MAG_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);
  logic [MAG_WIDTH+3:0] wide;
  assign wide  = ({4'd0, acc_i} << 3) + ({4'd0, acc_i} << 1) + {{MAG_WIDTH{1'b0}}, digit_i};
  assign ovf_o = |wide[MAG_WIDTH+3:MAG_WIDTH];
  assign acc_o = ovf_o ? '1 : wide[MAG_WIDTH-1:0];
endmodule

// File: rtl/day1_parser.sv
// day1_parser: ASCII L/R dial lines to registered direction/magnitude pulses
module day1_parser import day1_pkg::*; #(
  parameter int MAG_WIDTH   = DEF_MAG_WIDTH,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock_i,
  input  logic                   clear_n_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  input  logic                   byte_last_i,
  output logic                   direction_o,
  output logic [MAG_WIDTH-1:0]   magnitude_o,
  output logic                   instruction_valid_o,
  output logic [COUNT_WIDTH-1:0] instruction_count_o,
  output logic                   parse_error_o,
  output logic                   done_o
);
  parse_state_t state_q;
  logic [MAG_WIDTH-1:0] acc_q, acc_d;
  logic dir_q, seen_q, ovf;
  logic take, is_dig, is_lf, is_sp, is_dir, skip_cr, emit;
  day1_dec_acc #(.MAG_WIDTH(MAG_WIDTH)) u_dec_acc (
    .acc_i(acc_q),
    .digit_i(byte_data_i[3:0]),
    .acc_o(acc_d),
    .ovf_o(ovf)
  );
`ifdef DAY1_PARSER_CRLF_EN
  assign skip_cr = byte_data_i == CH_CR;
`else
  assign skip_cr = 1'b0;
`endif
  always_comb begin
    take   = byte_valid_i && !done_o;
    is_dig = byte_data_i >= CH_0 && byte_data_i <= CH_9;
    is_lf  = byte_data_i == CH_LF;
    is_sp  = byte_data_i == CH_SP;
    is_dir = byte_data_i == CH_L || byte_data_i == CH_R;
    emit   = take && state_q == DIGITS &&
             (is_dig ? byte_last_i : seen_q && (is_lf || (skip_cr && byte_last_i)));
  end
  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q             <= IDLE;
      acc_q               <= '0;
      dir_q               <= 1'b0;
      seen_q              <= 1'b0;
      direction_o         <= 1'b0;
      magnitude_o         <= '0;
      instruction_valid_o <= 1'b0;
      instruction_count_o <= '0;
      parse_error_o       <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      instruction_valid_o <= emit;
      if (emit) begin
        direction_o         <= dir_q;
        magnitude_o         <= is_dig ? acc_d : acc_q;
        instruction_count_o <= instruction_count_o + COUNT_WIDTH'(1);
      end
      if (take && !skip_cr) begin
        case (state_q)
          IDLE: begin
            if (is_dir) begin
              dir_q   <= byte_data_i == CH_R;
              acc_q   <= '0;
              seen_q  <= 1'b0;
              state_q <= DIGITS;
            end else if (!is_lf && !is_sp) begin
              parse_error_o <= 1'b1;
              state_q       <= SKIP;
            end
          end
          DIGITS: begin
            if (is_dig) begin
              acc_q  <= acc_d;
              seen_q <= 1'b1;
              if (ovf) parse_error_o <= 1'b1;
            end else if (is_lf) begin
              if (!seen_q) parse_error_o <= 1'b1;
              state_q <= IDLE;
            end else begin
              parse_error_o <= 1'b1;
              state_q       <= SKIP;
            end
          end
          default: if (is_lf) state_q <= IDLE;
        endcase
      end
      if (take && byte_last_i) begin
        done_o  <= 1'b1;
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_day1_parser.sv
// tb_day1_parser: directed and randomized streams checked against a line-level reference model
module tb_day1_parser;
  localparam int MW = 16;
  localparam int CW = 32;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  logic byte_valid = 1'b0;
  logic byte_last = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic direction, instruction_valid, parse_error, done;
  logic [MW-1:0] magnitude;
  logic [CW-1:0] instruction_count;
  int n_vec = 0;
  int n_bad = 0;
  int b2b = 0;
  logic prev_v = 1'b0;
  bit gap_en = 1'b0;
  bit sent_last = 1'b0;
  bit exp_err, exp_done;
  byte sent[$];
  logic obs_dir[$];
  int obs_mag[$];
  logic exp_dir[$];
  int exp_mag[$];

  always #5 clock = ~clock;

  day1_parser #(.MAG_WIDTH(MW), .COUNT_WIDTH(CW)) dut (
    .clock_i(clock),
    .clear_n_i(clear_n),
    .byte_valid_i(byte_valid),
    .byte_data_i(byte_data),
    .byte_last_i(byte_last),
    .direction_o(direction),
    .magnitude_o(magnitude),
    .instruction_valid_o(instruction_valid),
    .instruction_count_o(instruction_count),
    .parse_error_o(parse_error),
    .done_o(done)
  );

  always @(negedge clock) begin
    if (instruction_valid) begin
      obs_dir.push_back(direction);
      obs_mag.push_back(int'(magnitude));
    end
    if (instruction_valid && prev_v) b2b <= b2b + 1;
    prev_v <= instruction_valid;
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: split the accepted bytes into lines and judge each line as a whole.
  function automatic void eval_line(byte ln[$], bit term, bit fin);
    int k = 0;
    int nd = 0;
    int v = 0;
    bit d;
    while (k < ln.size() && ln[k] == " ") k++;
    if (k == ln.size()) return;
    if (ln[k] != "L" && ln[k] != "R") begin
      exp_err = 1'b1;
      return;
    end
    d = ln[k] == "R";
    for (int j = k + 1; j < ln.size(); j++) begin
      if (ln[j] < "0" || ln[j] > "9") begin
        exp_err = 1'b1;
        return;
      end
      v = v * 10 + (ln[j] - "0");
      nd++;
      if (v > 65535) begin
        v = 65535;
        exp_err = 1'b1;
      end
    end
    if (nd == 0) begin
      if (term) exp_err = 1'b1;
      return;
    end
    if (term || fin) begin
      exp_dir.push_back(d);
      exp_mag.push_back(v);
    end
  endfunction

  function automatic void model();
    byte ln[$];
    exp_dir.delete();
    exp_mag.delete();
    exp_err = 1'b0;
    exp_done = sent_last;
    foreach (sent[i]) begin
      if (sent[i] == 8'h0a) begin
        eval_line(ln, 1'b1, 1'b0);
        ln.delete();
      end else ln.push_back(sent[i]);
    end
    if (ln.size() > 0) eval_line(ln, 1'b0, sent_last);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    @(negedge clock);
    obs_dir.delete();
    obs_mag.delete();
    sent.delete();
    sent_last = 1'b0;
    clear_n = 1'b1;
  endtask

  task automatic put(byte b, bit last);
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data = b;
    byte_last = last;
    if (!sent_last) begin
      sent.push_back(b);
      sent_last = last;
    end
    if (gap_en) repeat ($urandom_range(0, 2)) begin
      @(negedge clock);
      byte_valid = 1'b0;
      byte_last = 1'b0;
    end
  endtask

  task automatic put_str(string s, bit last);
    for (int i = 0; i < s.len(); i++) put(s[i], last && i == s.len() - 1);
  endtask

  task automatic finish_case(string tag);
    repeat (4) begin
      @(negedge clock);
      byte_valid = 1'b0;
      byte_last = 1'b0;
    end
    model();
    check({tag, ":npulse"}, obs_mag.size(), exp_mag.size());
    for (int i = 0; i < exp_mag.size() && i < obs_mag.size(); i++) begin
      check({tag, ":dir"}, obs_dir[i], exp_dir[i]);
      check({tag, ":mag"}, obs_mag[i], exp_mag[i]);
    end
    check({tag, ":err"}, parse_error, exp_err);
    check({tag, ":done"}, done, exp_done);
    check({tag, ":count"}, instruction_count, exp_mag.size());
    check({tag, ":b2b"}, b2b, 0);
  endtask

  task automatic pulse_is(string tag, int i, bit d, int m);
    check({tag, ":have"}, obs_mag.size() > i, 1);
    if (obs_mag.size() > i) begin
      check({tag, ":dir"}, obs_dir[i], d);
      check({tag, ":mag"}, obs_mag[i], m);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, ":dir"}, direction, 0);
    check({tag, ":mag"}, magnitude, 0);
    check({tag, ":vld"}, instruction_valid, 0);
    check({tag, ":cnt"}, instruction_count, 0);
    check({tag, ":err"}, parse_error, 0);
    check({tag, ":done"}, done, 0);
  endtask

  task automatic run_random();
    byte pool[6] = '{8'h58, 8'h20, 8'h0d, 8'h4c, 8'h39, 8'h72};
    byte stim[$];
    bit ul;
    int nl = $urandom_range(2, 7);
    for (int l = 0; l < nl; l++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat ($urandom_range(0, 2)) stim.push_back(8'h20);
      end else if (kind == 1) begin
        stim.push_back(pool[$urandom_range(0, 5)]);
        stim.push_back(8'h31);
      end else begin
        int nd = (kind == 2) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        if ($urandom_range(0, 4) == 0) stim.push_back(8'h20);
        stim.push_back($urandom_range(0, 1) ? 8'h52 : 8'h4c);
        repeat (nd) stim.push_back(byte'(8'h30 + $urandom_range(0, 9)));
        if ($urandom_range(0, 9) == 0) stim.insert($urandom_range(0, stim.size()), pool[$urandom_range(0, 5)]);
      end
      stim.push_back(8'h0a);
    end
    ul = $urandom_range(0, 1) == 1;
    if (ul && $urandom_range(0, 1) == 1) void'(stim.pop_back());
    foreach (stim[i]) put(stim[i], ul && i == stim.size() - 1);
    if (ul) put_str("L1\n", 1'b0);
  endtask

  initial begin
    #1 check_zero("rst");
    do_reset();
    put_str("L68\nR48\n", 1'b0);
    finish_case("lf2");
    pulse_is("lf2p0", 0, 1'b0, 68);
    pulse_is("lf2p1", 1, 1'b1, 48);
    check("lf2:cnt", instruction_count, 2);
    check("lf2:err", parse_error, 0);
    do_reset();
    put_str("R5", 1'b1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_last = 1'b0;
    check("last:done_next", done, 1);
    check("last:vld_next", instruction_valid, 1);
    put_str("L1\n", 1'b0);
    finish_case("last");
    pulse_is("lastp0", 0, 1'b1, 5);
    check("last:cnt", instruction_count, 1);
    do_reset();
    put_str("R99999\n", 1'b0);
    finish_case("sat");
    pulse_is("satp0", 0, 1'b1, 65535);
    check("sat:err", parse_error, 1);
    do_reset();
    put_str("X12\nL3\n", 1'b0);
    finish_case("junk");
    pulse_is("junkp0", 0, 1'b0, 3);
    check("junk:cnt", instruction_count, 1);
    check("junk:err", parse_error, 1);
    for (int g = 0; g < 2; g++) begin
      gap_en = g == 1;
      do_reset();
      put_str("L\n\n\n  R7\n", 1'b0);
      finish_case(g == 1 ? "blank_gap" : "blank");
      pulse_is("blankp0", 0, 1'b1, 7);
      check("blank:err", parse_error, 1);
      check("blank:cnt", instruction_count, 1);
    end
    put_str("R12", 1'b0);
    @(negedge clock);
    byte_valid = 1'b0;
    clear_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clock);
    obs_dir.delete();
    obs_mag.delete();
    sent.delete();
    sent_last = 1'b0;
    clear_n = 1'b1;
    put_str("L4\n", 1'b0);
    finish_case("midrst");
    pulse_is("midrstp0", 0, 1'b0, 4);
    check("midrst:cnt", instruction_count, 1);
    for (int r = 0; r < 40; r++) begin
      gap_en = $urandom_range(0, 1) == 1;
      do_reset();
      run_random();
      finish_case("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
